// File: rtl/text_pkg.sv
// Shared types, geometry constants and the message-to-glyph ROM for the
// text overlay stage.
package text_pkg;

    typedef enum logic [2:0] {
        G_S = 3'd0,
        G_C = 3'd1,
        G_O = 3'd2,
        G_R = 3'd3,
        G_E = 3'd4,
        G_T = 3'd5,
        G_I = 3'd6,
        G_M = 3'd7
    } glyph_t;

    typedef enum logic [1:0] {
        MSG_SCORE = 2'd0,
        MSG_TIME  = 2'd1,
        MSG_MORE  = 2'd2,
        MSG_BLANK = 2'd3
    } msg_t;

    localparam int CELL_W  = 16;
    localparam int GLYPH_W = 14;
    localparam int GLYPH_H = 14;

    // Character count of each message, indexed by msg_t.
    localparam logic [5:0] MSG_LEN [4] = '{6'd5, 6'd4, 6'd4, 6'd0};

    // Glyph shown in a given character slot of a message; slots past the
    // message length never hit, so their value is irrelevant.
    function automatic glyph_t msg_glyph(input msg_t msg, input logic [5:0] slot);
        glyph_t g;
        g = G_S;
        case (msg)
            MSG_SCORE: begin
                case (slot)
                    6'd0:    g = G_S;
                    6'd1:    g = G_C;
                    6'd2:    g = G_O;
                    6'd3:    g = G_R;
                    6'd4:    g = G_E;
                    default: g = G_S;
                endcase
            end
            MSG_TIME: begin
                case (slot)
                    6'd0:    g = G_T;
                    6'd1:    g = G_I;
                    6'd2:    g = G_M;
                    6'd3:    g = G_E;
                    default: g = G_S;
                endcase
            end
            MSG_MORE: begin
                case (slot)
                    6'd0:    g = G_M;
                    6'd1:    g = G_O;
                    6'd2:    g = G_R;
                    6'd3:    g = G_E;
                    default: g = G_S;
                endcase
            end
            default: g = G_S;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/text_overlay_if.sv
// Pixel, message-select and font-stage signals of the text overlay.
// master = scan counters / font stage / controller side, slave = overlay.
interface text_overlay_if;
    logic       frame_start;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       pix_valid;
    logic       msg_sel_req;
    logic [1:0] msg_sel;
    logic       msg_sel_ack;
    logic       blink_en;
    logic [2:0] font_glyph;
    logic [3:0] font_row;
    logic [3:0] font_col;
    logic [5:0] font_pix;
    logic       text_valid;
    logic [5:0] text_idx;

    modport master (
        output frame_start, DrawX, DrawY, pix_valid, msg_sel_req, msg_sel,
               blink_en, font_pix,
        input  msg_sel_ack, font_glyph, font_row, font_col, text_valid, text_idx
    );

    modport slave (
        input  frame_start, DrawX, DrawY, pix_valid, msg_sel_req, msg_sel,
               blink_en, font_pix,
        output msg_sel_ack, font_glyph, font_row, font_col, text_valid, text_idx
    );
endinterface

// File: rtl/text_msg_ctrl.sv
// Frame-synchronous message switch (req/ack) and blink phase generator.
module text_msg_ctrl
    import text_pkg::*;
#(
    parameter int BLINK_FRAMES = 30
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic frame_start,
    input  logic req,
    input  msg_t sel,
    input  logic blink_en,
    output msg_t active_msg,
    output logic shown,
    output logic ack
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    localparam logic [5:0] LAST_FRAME = 6'(BLINK_FRAMES - 1);

    state_t     state_r, state_nxt_s;
    msg_t       pend_r, pend_nxt_s;
    msg_t       active_r, active_nxt_s;
    logic       ack_r, ack_nxt_s;
    logic [5:0] frame_cnt_r;
    logic       shown_r;

    // Next-state logic: latch a request in IDLE, apply it at the next frame start.
    always_comb begin
        state_nxt_s  = state_r;
        pend_nxt_s   = pend_r;
        active_nxt_s = active_r;
        ack_nxt_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req) begin
                    pend_nxt_s  = sel;
                    state_nxt_s = ST_PEND;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_PEND: begin
                if (frame_start) begin
                    active_nxt_s = pend_r;
                    ack_nxt_s    = 1'b1;
                    state_nxt_s  = ST_IDLE;
                end else begin
                    state_nxt_s = ST_PEND;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Pending/active message and the registered one-cycle ack.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            pend_r   <= MSG_SCORE;
            active_r <= MSG_SCORE;
            ack_r    <= 1'b0;
        end else begin
            pend_r   <= pend_nxt_s;
            active_r <= active_nxt_s;
            ack_r    <= ack_nxt_s;
        end
    end

    // Blink: count frames, toggle visibility every BLINK_FRAMES frames.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            frame_cnt_r <= 6'd0;
            shown_r     <= 1'b1;
        end else if (!blink_en) begin
            frame_cnt_r <= 6'd0;
            shown_r     <= 1'b1;
        end else if (frame_start) begin
            if (frame_cnt_r == LAST_FRAME) begin
                frame_cnt_r <= 6'd0;
                shown_r     <= ~shown_r;
            end else begin
                frame_cnt_r <= frame_cnt_r + 6'd1;
            end
        end
    end

    assign active_msg = active_r;
    assign shown      = shown_r;
    assign ack        = ack_r;

endmodule

// File: rtl/text_overlay.sv
// Two-stage pixel pipeline drawing a short banner string at (X0, Y0):
// stage 1 addresses the font stage, stage 2 registers its palette index.
module text_overlay
    import text_pkg::*;
#(
    parameter int X0           = 240,
    parameter int Y0           = 16,
    parameter int BLINK_FRAMES = 30
) (
    input logic           Clk,
    input logic           Reset_n,
    text_overlay_if.slave bus
);

    msg_t       active_msg_s;
    logic       shown_s;
    logic       ack_s;

    logic [9:0] rx_s;
    logic [9:0] ry_s;
    logic [5:0] slot_s;
    logic [3:0] col_s;
    logic       hit_s;
    logic       pix_hit_s;

    logic [2:0] glyph_r;
    logic [3:0] row_r;
    logic [3:0] col_r;
    logic       hit1_r;
    logic       text_valid_r;
    logic [5:0] text_idx_r;

    text_msg_ctrl #(
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_ctrl (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .frame_start (bus.frame_start),
        .req         (bus.msg_sel_req),
        .sel         (msg_t'(bus.msg_sel)),
        .blink_en    (bus.blink_en),
        .active_msg  (active_msg_s),
        .shown       (shown_s),
        .ack         (ack_s)
    );

    // Box hit test; left/top underflow wraps to large values and misses.
    always_comb begin
        rx_s   = bus.DrawX - 10'(X0);
        ry_s   = bus.DrawY - 10'(Y0);
        slot_s = rx_s[9:4];
        col_s  = rx_s[3:0];
        hit_s  = bus.pix_valid
               && (slot_s < MSG_LEN[active_msg_s])
               && (col_s < 4'(GLYPH_W))
               && (ry_s < 10'(GLYPH_H));
    end

    // Stage 1: font addresses (zero on a miss) and the hit flag.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            glyph_r <= 3'd0;
            row_r   <= 4'd0;
            col_r   <= 4'd0;
            hit1_r  <= 1'b0;
        end else begin
            hit1_r <= hit_s;
            if (hit_s) begin
                glyph_r <= msg_glyph(active_msg_s, slot_s);
                row_r   <= ry_s[3:0];
                col_r   <= col_s;
            end else begin
                glyph_r <= 3'd0;
                row_r   <= 4'd0;
                col_r   <= 4'd0;
            end
        end
    end

    assign pix_hit_s = hit1_r && shown_s && (bus.font_pix != 6'd0);

    // Stage 2: register the palette index for visible, non-transparent pixels.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            text_valid_r <= 1'b0;
            text_idx_r   <= 6'd0;
        end else begin
            text_valid_r <= pix_hit_s;
            text_idx_r   <= pix_hit_s ? bus.font_pix : 6'd0;
        end
    end

    assign bus.font_glyph  = glyph_r;
    assign bus.font_row    = row_r;
    assign bus.font_col    = col_r;
    assign bus.text_valid  = text_valid_r;
    assign bus.text_idx    = text_idx_r;
    assign bus.msg_sel_ack = ack_s;

endmodule

// File: tb/tb_text_overlay.sv
// Directed bench for text_overlay: table of pixel vectors plus hand-written
// sequences for message switching, blink and mid-frame reset.
module tb_text_overlay;

    logic Clk = 1'b0;
    logic Reset_n;
    int   checks = 0;
    int   errors = 0;

    text_overlay_if bus ();

    text_overlay #(
        .X0           (240),
        .Y0           (16),
        .BLINK_FRAMES (2)
    ) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic       pv;
        logic [5:0] stub;
        logic [2:0] g;
        logic [3:0] r;
        logic [3:0] c;
        logic       v;
        logic [5:0] idx;
    } vec_t;

    vec_t vecs [12];
    logic exp_vis [6];

    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s actual %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_pix(input int x, input int y, input logic pv, input int stub);
        bus.DrawX     = 10'(x);
        bus.DrawY     = 10'(y);
        bus.pix_valid = pv;
        bus.font_pix  = 6'(stub);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_glyph"}, bus.font_glyph, 0);
        chk({tag, "_row"},   bus.font_row,   0);
        chk({tag, "_col"},   bus.font_col,   0);
        chk({tag, "_valid"}, bus.text_valid, 0);
        chk({tag, "_idx"},   bus.text_idx,   0);
        chk({tag, "_ack"},   bus.msg_sel_ack, 0);
    endtask

    // Switch to a message: request, one frame start, ack must pulse on it.
    task automatic switch_msg(input int m, input string tag);
        bus.msg_sel_req = 1'b1;
        bus.msg_sel     = 2'(m);
        step();
        chk({tag, "_noack_early"}, bus.msg_sel_ack, 0);
        bus.frame_start = 1'b1;
        step();
        chk({tag, "_ack"}, bus.msg_sel_ack, 1);
        bus.frame_start = 1'b0;
        bus.msg_sel_req = 1'b0;
        step();
        chk({tag, "_ack_drop"}, bus.msg_sel_ack, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual timeout expected finish");
        $fatal(1);
    end

    initial begin
        int acks;

        //            x     y     pv   stub   g     r     c     v     idx
        vecs[0]  = '{10'd240, 10'd16, 1'b1, 6'd5,  3'd0, 4'd0,  4'd0,  1'b1, 6'd5};
        vecs[1]  = '{10'd254, 10'd16, 1'b1, 6'd5,  3'd0, 4'd0,  4'd0,  1'b0, 6'd0};
        vecs[2]  = '{10'd320, 10'd16, 1'b1, 6'd5,  3'd0, 4'd0,  4'd0,  1'b0, 6'd0};
        vecs[3]  = '{10'd239, 10'd16, 1'b1, 6'd5,  3'd0, 4'd0,  4'd0,  1'b0, 6'd0};
        vecs[4]  = '{10'd257, 10'd20, 1'b1, 6'd9,  3'd1, 4'd4,  4'd1,  1'b1, 6'd9};
        vecs[5]  = '{10'd305, 10'd29, 1'b1, 6'd33, 3'd4, 4'd13, 4'd1,  1'b1, 6'd33};
        vecs[6]  = '{10'd305, 10'd30, 1'b1, 6'd33, 3'd0, 4'd0,  4'd0,  1'b0, 6'd0};
        vecs[7]  = '{10'd240, 10'd15, 1'b1, 6'd5,  3'd0, 4'd0,  4'd0,  1'b0, 6'd0};
        vecs[8]  = '{10'd240, 10'd16, 1'b0, 6'd5,  3'd0, 4'd0,  4'd0,  1'b0, 6'd0};
        vecs[9]  = '{10'd275, 10'd17, 1'b1, 6'd0,  3'd2, 4'd1,  4'd3,  1'b0, 6'd0};
        vecs[10] = '{10'd293, 10'd18, 1'b1, 6'd63, 3'd3, 4'd2,  4'd5,  1'b1, 6'd63};
        vecs[11] = '{10'd253, 10'd16, 1'b1, 6'd7,  3'd0, 4'd0,  4'd13, 1'b1, 6'd7};

        exp_vis = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

        Reset_n         = 1'b0;
        bus.frame_start = 1'b0;
        bus.msg_sel_req = 1'b0;
        bus.msg_sel     = 2'd0;
        bus.blink_en    = 1'b0;
        set_pix(240, 16, 1'b1, 5);
        step();
        step();
        chk_all_zero("reset");
        Reset_n = 1'b1;
        set_pix(0, 0, 1'b0, 0);
        step();

        // Table: SCORE is active after reset.
        for (int i = 0; i < 12; i++) begin
            set_pix(vecs[i].x, vecs[i].y, vecs[i].pv, vecs[i].stub);
            step();
            chk($sformatf("v%0d_glyph", i), bus.font_glyph, vecs[i].g);
            chk($sformatf("v%0d_row", i),   bus.font_row,   vecs[i].r);
            chk($sformatf("v%0d_col", i),   bus.font_col,   vecs[i].c);
            step();
            chk($sformatf("v%0d_valid", i), bus.text_valid, vecs[i].v);
            chk($sformatf("v%0d_idx", i),   bus.text_idx,   vecs[i].idx);
        end
        set_pix(0, 0, 1'b0, 0);

        // Request TIME held high, frame start 10 cycles later.
        bus.msg_sel_req = 1'b1;
        bus.msg_sel     = 2'd1;
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.msg_sel_ack) acks = acks + 1;
        end
        chk("time_no_early_ack", acks, 0);
        bus.frame_start = 1'b1;
        step();
        chk("time_ack", bus.msg_sel_ack, 1);
        bus.frame_start = 1'b0;
        bus.msg_sel_req = 1'b0;
        acks = 0;
        for (int i = 0; i < 20; i++) begin
            bus.frame_start = (i == 8) ? 1'b1 : 1'b0;
            step();
            if (bus.msg_sel_ack) acks = acks + 1;
        end
        bus.frame_start = 1'b0;
        chk("time_no_second_ack", acks, 0);
        set_pix(288, 16, 1'b1, 12);
        step();
        chk("time_slot3_glyph", bus.font_glyph, 4);
        step();
        chk("time_slot3_valid", bus.text_valid, 1);
        chk("time_slot3_idx",   bus.text_idx,   12);
        set_pix(304, 16, 1'b1, 12);
        step();
        step();
        chk("time_slot4_valid", bus.text_valid, 0);
        chk("time_slot4_glyph", bus.font_glyph, 0);

        // Request for blank arriving together with frame start.
        bus.msg_sel_req = 1'b1;
        bus.msg_sel     = 2'd3;
        bus.frame_start = 1'b1;
        step();
        chk("coinc_no_ack", bus.msg_sel_ack, 0);
        bus.frame_start = 1'b0;
        step();
        step();
        chk("coinc_still_no_ack", bus.msg_sel_ack, 0);
        bus.frame_start = 1'b1;
        step();
        chk("coinc_ack_next_frame", bus.msg_sel_ack, 1);
        bus.frame_start = 1'b0;
        bus.msg_sel_req = 1'b0;
        set_pix(240, 16, 1'b1, 5);
        step();
        step();
        chk("blank_valid_240", bus.text_valid, 0);
        chk("blank_glyph_240", bus.font_glyph, 0);
        set_pix(257, 20, 1'b1, 5);
        step();
        step();
        chk("blank_valid_257", bus.text_valid, 0);
        chk("blank_col_257",   bus.font_col,   0);

        // Back to SCORE, then blink with two frames per half-period.
        switch_msg(0, "score");
        set_pix(240, 16, 1'b1, 5);
        bus.blink_en = 1'b1;
        step();
        for (int k = 0; k < 6; k++) begin
            bus.frame_start = 1'b1;
            step();
            bus.frame_start = 1'b0;
            step();
            step();
            chk($sformatf("blink_f%0d_valid", k + 1), bus.text_valid, exp_vis[k]);
            chk($sformatf("blink_f%0d_idx", k + 1),   bus.text_idx,   exp_vis[k] ? 5 : 0);
            chk($sformatf("blink_f%0d_col", k + 1),   bus.font_col,   0);
        end
        set_pix(257, 20, 1'b1, 5);
        step();
        chk("blink_hidden_addr", bus.font_glyph, 1);
        step();
        chk("blink_hidden_valid", bus.text_valid, 0);
        bus.blink_en = 1'b0;
        step();
        step();
        chk("blink_off_valid", bus.text_valid, 1);
        chk("blink_off_idx",   bus.text_idx,   5);

        // Reset while a request is pending and a hit is in the pipeline.
        bus.msg_sel_req = 1'b1;
        bus.msg_sel     = 2'd2;
        step();
        bus.msg_sel_req = 1'b0;
        set_pix(257, 20, 1'b1, 9);
        step();
        chk("pre_rst_glyph", bus.font_glyph, 1);
        step();
        chk("pre_rst_valid", bus.text_valid, 1);
        Reset_n = 1'b0;
        step();
        chk_all_zero("midrst");
        Reset_n = 1'b1;
        acks = 0;
        for (int i = 0; i < 30; i++) begin
            bus.frame_start = (i % 10 == 3) ? 1'b1 : 1'b0;
            step();
            if (bus.msg_sel_ack) acks = acks + 1;
        end
        bus.frame_start = 1'b0;
        chk("midrst_no_ack", acks, 0);
        set_pix(305, 16, 1'b1, 5);
        step();
        chk("midrst_score_glyph", bus.font_glyph, 4);
        step();
        chk("midrst_score_valid", bus.text_valid, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
